pixel_plot_buffer: RTL
======================

Name: pixel_plot_buffer

Overview:
- Downstream stage of the screen-fill and shape-drawing engines. It consumes their per-cycle plot strobes (x, y, colour, plot) and turns them into framebuffer write transactions.
- It clips off-screen coordinates, linearises (x, y) to a framebuffer address, and absorbs framebuffer stalls in a small FIFO.
- The drawing engines never stall, so this block reports overflow instead of back-pressuring them.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SCREEN_W, 160: visible columns.
- SCREEN_H, 120: visible rows.
- ADDR_W, 15: framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- vga_x  in  8  plot column.
- vga_y  in  7  plot row.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  plot strobe; one pixel per high cycle.
- fb_addr  out  ADDR_W  framebuffer write address.
- fb_wrdata  out  3  framebuffer write colour.
- fb_we  out  1  write request; held until accepted.
- fb_ack  in  1  framebuffer accepts the write in a cycle where fb_we=1 and fb_ack=1.
- full  out  1  FIFO holds DEPTH entries.
- idle  out  1  FIFO empty and no write outstanding.
- overflow  out  1  sticky: a strobe was dropped because the FIFO was full.
- clip_count  out  16  number of off-screen strobes discarded; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, rst=1) clears the FIFO, write pointer and read pointer, occupancy, overflow and clip_count.
  - State goes to S_IDLE.
  - Outputs: fb_we=0, fb_addr=0, fb_wrdata=0, full=0, idle=1.
  - Reset mid-write abandons the pending write with no completion.
- Clipping: a strobe with vga_x >= SCREEN_W or vga_y >= SCREEN_H is not enqueued. clip_count increments, saturating.
- Address computation: addr = vga_y*SCREEN_W + vga_x.
  - Computed at enqueue and stored in the FIFO with the colour (ADDR_W+3 bits per entry).
  - For the default SCREEN_W the multiply is implemented as (y<<7)+(y<<5)+x, zero-extended to ADDR_W. No truncation is permitted.
- Enqueue: an in-range strobe is accepted when occupancy < DEPTH, or when occupancy == DEPTH and a pop occurs in the same cycle.
  - Otherwise the strobe is dropped and overflow is set to 1; it stays 1 until rst.
  - Clipped strobes never set overflow.
- Pointers wrap modulo DEPTH. Occupancy is held in a separate counter 0..DEPTH.
- Write FSM, two states:
  - S_IDLE: fb_we=0. If the FIFO is non-empty, load the head into the fb_addr/fb_wrdata registers, pop it, and go to S_WRITE.
  - S_WRITE: fb_we=1; fb_addr and fb_wrdata are held stable.
    - On fb_ack: if the FIFO is non-empty, load and pop the next head and stay in S_WRITE (back-to-back, one write per cycle). Otherwise go to S_IDLE.
    - No ack: hold.
- Latency: a strobe at edge N into an empty FIFO with the FSM in S_IDLE gives fb_we=1 after edge N+1. Throughput is one pixel per cycle while fb_ack stays high.
- Simultaneous push and pop at full: occupancy is unchanged and full stays 1.
- Simultaneous push and pop at empty is impossible, because a pop needs prior contents. The pushed entry becomes head after the edge.
- idle = (occupancy==0) && (state==S_IDLE), combinational from registered state.
- vga_plot low: no action on that cycle, regardless of the x, y and colour values.

Decomposition:
- Package pixel_pkg holds:
  - SCREEN_W, SCREEN_H, ADDR_W defaults;
  - a typedef struct plot_entry_t {addr, colour};
  - the state enum {S_IDLE, S_WRITE}.
- Sub-module plot_fifo: a synchronous DEPTH-entry FIFO of plot_entry_t with push, pop, full, empty and count.
- The top level owns clipping, address computation, counters and the FSM.

Test Plan:
- Reset then plot (x=5, y=3, colour=3'b101) with fb_ack held at 1 -> fb_we=1 for one cycle two edges later; fb_addr=485, fb_wrdata=5; idle returns to 1.
- Corner pixels (0,0) and (159,119) -> fb_addr=0 and fb_addr=19199 respectively.
- Off-screen strobes at (160,0) and (0,120) -> no fb_we; clip_count=2; overflow=0.
- fb_ack held 0, then 6 consecutive strobes with DEPTH=4 -> 1 write held in S_WRITE, 4 in the FIFO, 1 dropped. Expect full=1 and overflow=1. Releasing ack produces exactly 5 writes in order, one per cycle.
- Full FIFO with a simultaneous push and ack-driven pop -> full stays 1, no overflow, write order preserved.
- rst asserted mid-burst while fb_we=1 -> fb_we=0 immediately (asynchronously); idle=1; overflow and clip_count=0; the next strobe behaves as in the first scenario.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared geometry defaults, FIFO entry type and write-FSM states for the pixel plot path.
package pixel_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned ADDR_W   = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        colour;
    } plot_entry_t;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot entries. The caller guarantees push only when space is free
// (or a pop happens in the same cycle) and pop only when non-empty.
module plot_fifo
    import pixel_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  plot_entry_t      i_data,
    input  logic             i_pop,
    output plot_entry_t      o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    plot_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/pixel_plot_buffer.sv
// Turns drawing-engine plot strobes into framebuffer writes: clips, linearises (x, y),
// buffers through a small FIFO and reports drops instead of stalling the engines.
module pixel_plot_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SCREEN_W = pixel_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = pixel_pkg::SCREEN_H,
    parameter int unsigned ADDR_W   = pixel_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_vga_x,
    input  logic [6:0]        i_vga_y,
    input  logic [2:0]        i_vga_colour,
    input  logic              i_vga_plot,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [2:0]        o_fb_wrdata,
    output logic              o_fb_we,
    input  logic              i_fb_ack,
    output logic              o_full,
    output logic              o_idle,
    output logic              o_overflow,
    output logic [15:0]       o_clip_count
);

    import pixel_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_t            r_state;
    state_t            w_state_next;
    plot_entry_t       w_entry;
    plot_entry_t       w_head;
    logic              w_in_range;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_y_ext;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [2:0]        r_fb_wrdata;
    logic              r_overflow;
    logic [15:0]       r_clip_count;

    assign w_in_range = (32'(i_vga_x) < SCREEN_W) && (32'(i_vga_y) < SCREEN_H);

    assign w_x_ext = ADDR_W'(i_vga_x);
    assign w_y_ext = ADDR_W'(i_vga_y);

    if (SCREEN_W == 160) begin : g_addr_shift
        // 160 = 128 + 32, so the row offset needs only two shifts and an add.
        assign w_addr = (w_y_ext << 7) + (w_y_ext << 5) + w_x_ext;
    end else begin : g_addr_mul
        assign w_addr = (w_y_ext * ADDR_W'(SCREEN_W)) + w_x_ext;
    end

    assign w_entry = '{addr: w_addr, colour: i_vga_colour};

    // A full FIFO still accepts a strobe when the head leaves in the same cycle.
    assign w_push = i_vga_plot && w_in_range && (!w_full || w_pop);

    plot_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_fb_ack) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_fb_addr    <= '0;
            r_fb_wrdata  <= '0;
            r_overflow   <= 1'b0;
            r_clip_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_fb_addr   <= w_head.addr;
                r_fb_wrdata <= w_head.colour;
            end
            if (i_vga_plot && w_in_range && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (i_vga_plot && !w_in_range && (r_clip_count != 16'hFFFF)) begin
                r_clip_count <= r_clip_count + 16'd1;
            end
        end
    end

    assign o_fb_addr    = r_fb_addr;
    assign o_fb_wrdata  = r_fb_wrdata;
    assign o_fb_we      = (r_state == S_WRITE);
    assign o_full       = w_full;
    assign o_idle       = (w_count == '0) && (r_state == S_IDLE);
    assign o_overflow   = r_overflow;
    assign o_clip_count = r_clip_count;

endmodule
